traffic_phase_controller: RTL
=============================

# traffic_phase_controller

Parametrised N-approach traffic signal controller. It generalises the fixed four-output controller (M1/S/M2/MT) to `N_DIR` approaches with programmable phase durations and vehicle-actuated phase skipping. It sits at the top of the signal path, driving one 3-bit lamp group per approach, and is clocked from the 1 Hz system tick, so durations are in seconds.

## Interface
- `N_DIR`, 4: number of approaches; must be ≥ 2.
- `GREEN_MIN`, 10: minimum green cycles; must be ≥ 1.
- `GREEN_MAX`, 30: maximum green cycles; must be ≥ `GREEN_MIN`.
- `YELLOW_CYC`, 3: yellow cycles; must be ≥ 1.
- `ALLRED_CYC`, 2: all-red clearance cycles; must be ≥ 1.
- `FLASH_CYC`, 1: half-period of flashing yellow, in cycles.
- `TW`, 8: phase timer width; must hold `GREEN_MAX`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req` in `N_DIR`: per-approach vehicle detector, level or pulse.
- `flash` in 1: flashing-yellow request (only with `FLASH_MODE_EN`).
- `light` out `3*N_DIR`: lamp group d at `[3d+2:3d]`, bits {red, yellow, green}, one-hot or all-zero.
- `cur_dir` out `$clog2(N_DIR)`: approach currently served.
- `phase_start` out 1: one-cycle pulse in the first GREEN cycle.

## Operation
- States: ALL_RED, GREEN, YELLOW, plus FLASH when the macro is defined.
- Reset values:
  - state = ALL_RED; timer = 0
  - `cur_dir` = `N_DIR-1`; pending = 0
  - all `light` groups = 3'b100; `phase_start` = 0
- Demand latch: `pend <= (pend | req) & ~clr`.
  - `clr` is one-hot on `cur_dir` in the first GREEN cycle only.
  - Clear wins over a simultaneous `req` on the same approach.
- ALL_RED → GREEN once `ALLRED_CYC` cycles have elapsed.
  - Next approach: first d with `pend[d]=1`, searching `cur_dir+1`, `cur_dir+2`, … modulo `N_DIR`.
  - If no approach is pending, use `cur_dir+1 mod N_DIR`; the controller falls back to fixed-time round-robin.
- GREEN → YELLOW at green cycle count g, where `GREEN_MIN ≤ g ≤ GREEN_MAX`:
  - Gap-out: if g ≥ `GREEN_MIN` and `pend[cur_dir]=0` and some other `pend` bit is 1, end green.
  - Otherwise end green when g = `GREEN_MAX`.
- YELLOW → ALL_RED after `YELLOW_CYC` cycles.
- Served approach lamps: GREEN = 3'b001, YELLOW = 3'b010. All other approaches show 3'b100 at all times.
- Safety invariant: at most one approach is non-red in any cycle.

## Timing
- All outputs are registered.
- `light`, `cur_dir` and `phase_start` change on the edge that enters the new state.
- Each state occupies exactly its cycle count: ALL_RED = `ALLRED_CYC`, YELLOW = `YELLOW_CYC`, GREEN = g.
- Cycle 1 of ALL_RED is the first edge after `rst` deasserts.
- `req` sampled at edge k takes effect in the gap-out decision at edge k+1.
- `rst` asserted in any state returns all outputs to their reset values on the next edge. There is no yellow on reset.
- The timer saturates at `GREEN_MAX`. It never wraps.

## Configuration
- `FLASH_MODE_EN` defined: the `flash` port and the FLASH state exist.
  - `flash=1` is acted on only when ALL_RED completes, so green is never cut short.
  - Instead of GREEN, the controller enters FLASH: all groups alternate 3'b010 / 3'b000 every `FLASH_CYC` cycles, starting with 3'b010.
  - `pend` keeps latching during FLASH.
  - When `flash=0` is sampled, the controller enters ALL_RED, then resumes normal selection.
- `FLASH_MODE_EN` undefined: no `flash` port and no FLASH state. Behaviour is identical to the macro-defined build with `flash=0`.

## Test plan
Overrides for all scenarios: `N_DIR=4`, `GREEN_MIN=4`, `GREEN_MAX=8`, `YELLOW_CYC=2`, `ALLRED_CYC=1`.
- No demand, `req=0`, reset released → approaches are served 0,1,2,3,0…; each gets 8 G, 2 Y, 1 R; the full cycle is 44 cycles; `phase_start` pulses every 11 cycles; never two non-red groups.
- `req[2]` held high from reset → approach 2 green first, then only approach 2 repeats (8 G / 2 Y / 1 R); `cur_dir` stays 2.
- Approach 0 in GREEN, one-cycle `req[3]` pulse at green cycle 1, `req[0]=0` → green ends after exactly 4 cycles; after Y, R the next green is approach 3, skipping 1 and 2.
- `rst` pulsed at GREEN cycle 5 of approach 1 → next edge: all groups 3'b100, `cur_dir=3`, `pend=0`; 1 cycle later approach 0 is green.
- `req[0]` and the first GREEN cycle of approach 0 coincide → `pend[0]` ends at 0.
- `FLASH_MODE_EN`: `flash=1` during approach 1 green → approach 1 completes 8 G, 2 Y, 1 R; then all groups toggle 3'b010/3'b000 each cycle; `flash=0` → 1 all-red cycle, then approach 2 green.

Source files
------------

// File: rtl/traffic_phase_controller.sv
// N-approach actuated traffic signal controller: ALL_RED -> GREEN -> YELLOW per approach,
// with gap-out on competing demand. Define FLASH_MODE_EN to add the flash port and FLASH state.
module traffic_phase_controller #(
    parameter int N_DIR      = 4,
    parameter int GREEN_MIN  = 10,
    parameter int GREEN_MAX  = 30,
    parameter int YELLOW_CYC = 3,
    parameter int ALLRED_CYC = 2,
    parameter int FLASH_CYC  = 1,
    parameter int TW         = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_DIR-1:0]           req,
`ifdef FLASH_MODE_EN
    input  logic                       flash,
`endif
    output logic [3*N_DIR-1:0]         light,
    output logic [$clog2(N_DIR)-1:0]   cur_dir,
    output logic                       phase_start
);

    localparam int DW = $clog2(N_DIR);
    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;

    if (N_DIR < 2 || GREEN_MIN < 1 || GREEN_MAX < GREEN_MIN || YELLOW_CYC < 1 ||
        ALLRED_CYC < 1 || FLASH_CYC < 1 || GREEN_MAX >= (1 << TW)) begin : g_bad_params
        $error("traffic_phase_controller: invalid parameter set");
    end

`ifdef FLASH_MODE_EN
    typedef enum logic [1:0] {ALL_RED, GREEN, YELLOW, FLASH} state_t;
`else
    typedef enum logic [1:0] {ALL_RED, GREEN, YELLOW} state_t;
`endif

    state_t             state, state_nxt;
    logic [TW-1:0]      timer, timer_nxt;
    logic [DW-1:0]      dir_nxt, sel_dir, next_dir, hi_dir, lo_dir;
    logic               hi_hit, lo_hit;
    logic [N_DIR-1:0]   pend, cur_mask, clr, cand;
    logic [3*N_DIR-1:0] light_nxt;
    logic               phase_start_nxt;
`ifdef FLASH_MODE_EN
    logic               flash_on, flash_on_nxt;
`endif

    function automatic logic [3*N_DIR-1:0] lamp_group(input logic [DW-1:0] dir, input logic [2:0] lamp);
        lamp_group = {N_DIR{LAMP_RED}};
        for (int unsigned d = 0; d < N_DIR; d++)
            if (DW'(d) == dir) lamp_group[3*d +: 3] = lamp;
    endfunction

    always_comb begin
        cur_mask = {{(N_DIR-1){1'b0}}, 1'b1} << cur_dir;
        clr      = (state == GREEN && timer == '0) ? cur_mask : '0;
        cand     = pend | req;
    end

    // Searches cur_dir+1 .. N_DIR-1 first, then wraps to 0 .. cur_dir. The live req is
    // folded in so a detector already active when ALL_RED ends is not missed.
    always_comb begin
        next_dir = (cur_dir == DW'(N_DIR-1)) ? '0 : cur_dir + 1'b1;
        hi_hit   = 1'b0;
        lo_hit   = 1'b0;
        hi_dir   = '0;
        lo_dir   = '0;
        for (int unsigned d = 0; d < N_DIR; d++) begin
            if (cand[d] && DW'(d) > cur_dir && !hi_hit) begin
                hi_hit = 1'b1;
                hi_dir = DW'(d);
            end
            if (cand[d] && DW'(d) <= cur_dir && !lo_hit) begin
                lo_hit = 1'b1;
                lo_dir = DW'(d);
            end
        end
        sel_dir = hi_hit ? hi_dir : (lo_hit ? lo_dir : next_dir);
    end

    always_comb begin
        state_nxt       = state;
        timer_nxt       = (timer == TW'(GREEN_MAX)) ? timer : timer + 1'b1;
        dir_nxt         = cur_dir;
        light_nxt       = light;
        phase_start_nxt = 1'b0;
`ifdef FLASH_MODE_EN
        flash_on_nxt    = flash_on;
`endif
        case (state)
            ALL_RED: begin
                light_nxt = {N_DIR{LAMP_RED}};
                if (timer == TW'(ALLRED_CYC-1)) begin
                    timer_nxt       = '0;
                    state_nxt       = GREEN;
                    dir_nxt         = sel_dir;
                    light_nxt       = lamp_group(sel_dir, LAMP_GRN);
                    phase_start_nxt = 1'b1;
`ifdef FLASH_MODE_EN
                    if (flash) begin
                        state_nxt       = FLASH;
                        dir_nxt         = cur_dir;
                        light_nxt       = {N_DIR{LAMP_YEL}};
                        phase_start_nxt = 1'b0;
                        flash_on_nxt    = 1'b1;
                    end
`endif
                end
            end
            GREEN: begin
                light_nxt = lamp_group(cur_dir, LAMP_GRN);
                if ((timer >= TW'(GREEN_MIN-1) && (pend & cur_mask) == '0 && (pend & ~cur_mask) != '0)
                    || timer == TW'(GREEN_MAX-1)) begin
                    state_nxt = YELLOW;
                    timer_nxt = '0;
                    light_nxt = lamp_group(cur_dir, LAMP_YEL);
                end
            end
            YELLOW: begin
                light_nxt = lamp_group(cur_dir, LAMP_YEL);
                if (timer == TW'(YELLOW_CYC-1)) begin
                    state_nxt = ALL_RED;
                    timer_nxt = '0;
                    light_nxt = {N_DIR{LAMP_RED}};
                end
            end
`ifdef FLASH_MODE_EN
            FLASH: begin
                if (!flash) begin
                    state_nxt = ALL_RED;
                    timer_nxt = '0;
                    light_nxt = {N_DIR{LAMP_RED}};
                end else if (timer == TW'(FLASH_CYC-1)) begin
                    timer_nxt    = '0;
                    flash_on_nxt = !flash_on;
                    light_nxt    = flash_on ? '0 : {N_DIR{LAMP_YEL}};
                end else begin
                    light_nxt = flash_on ? {N_DIR{LAMP_YEL}} : '0;
                end
            end
`endif
            default: begin
                state_nxt = ALL_RED;
                timer_nxt = '0;
                light_nxt = {N_DIR{LAMP_RED}};
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ALL_RED;
            timer       <= '0;
            cur_dir     <= DW'(N_DIR-1);
            pend        <= '0;
            light       <= {N_DIR{LAMP_RED}};
            phase_start <= 1'b0;
`ifdef FLASH_MODE_EN
            flash_on    <= 1'b0;
`endif
        end else begin
            state       <= state_nxt;
            timer       <= timer_nxt;
            cur_dir     <= dir_nxt;
            pend        <= (pend | req) & ~clr;
            light       <= light_nxt;
            phase_start <= phase_start_nxt;
`ifdef FLASH_MODE_EN
            flash_on    <= flash_on_nxt;
`endif
        end
    end

endmodule
